pwm_duty_ramp: RTL and testbench

Upstream stage of the TT06 PWM generator. It accepts a target duty cycle and slews the duty actually driven into the PWM core towards that target. Each step is a programmable size, and one step is taken every RATE_DIV clocks. With synchronisation enabled, each new duty value is committed only at a PWM period boundary, so the PWM output never glitches mid-period.

---
 rtl/pwm_duty_ramp.sv | 144 ++++++++++++++
 tb/tb_pwm_duty_ramp.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_ramp.sv
// pwm_duty_ramp: slews the duty word fed to the PWM compare register toward
// a loaded target, one clamped step every RATE_DIV clocks.
// Optional build macro PWM_RAMP_SYNC_EN: when defined, each computed step is
// held in WAIT_EDGE and committed only on period_end. This keeps duty changes
// aligned to PWM period boundaries. When undefined, a step is committed at
// the prescaler terminal count.
module pwm_duty_ramp #(
  parameter int WIDTH    = 8,
  parameter int RATE_DIV = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] tgt_duty,
  input  logic             tgt_load,
  input  logic [3:0]       step_size,
  input  logic             period_end,
  output logic [WIDTH-1:0] duty_out,
  output logic             duty_upd,
  output logic             busy
);

  localparam int PW = $clog2(RATE_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(RATE_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    RAMP
`ifdef PWM_RAMP_SYNC_EN
    , WAIT_EDGE
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cur_q, cur_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             upd_q, upd_d;
  logic [WIDTH-1:0] step_val;
`ifdef PWM_RAMP_SYNC_EN
  logic [WIDTH-1:0] nxt_q, nxt_d;
`else
  logic             unused_period_end;
  assign unused_period_end = period_end;
`endif

  // One step from cur toward tgt, computed one bit wider so that it cannot
  // wrap. The result is clamped to tgt so the ramp never overshoots.
  function automatic logic [WIDTH-1:0] step_toward(
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] tgt,
    input logic [3:0]       stp
  );
    logic [WIDTH:0] s;
    logic [WIDTH:0] acc;
    s = (WIDTH+1)'((stp == 4'd0) ? 4'd1 : stp);
    if (tgt > cur) begin
      acc = {1'b0, cur} + s;
      if (acc >= {1'b0, tgt}) acc = {1'b0, tgt};
    end else begin
      acc = {1'b0, cur} - s;
      if (acc[WIDTH] || (acc <= {1'b0, tgt})) acc = {1'b0, tgt};
    end
    return acc[WIDTH-1:0];
  endfunction

  assign step_val = step_toward(cur_q, tgt_q, step_size);

  // Next-state logic: a target load overrides everything; otherwise prescale and commit
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    pre_d   = pre_q;
    upd_d   = 1'b0;
`ifdef PWM_RAMP_SYNC_EN
    nxt_d   = nxt_q;
`endif
    if (ena) begin
      if (tgt_load) begin
        tgt_d   = tgt_duty;
        pre_d   = '0;
        state_d = (tgt_duty != cur_q) ? RAMP : IDLE;
      end else begin
        case (state_q)
          RAMP: begin
            if (pre_q == PRE_LAST) begin
              pre_d = '0;
`ifdef PWM_RAMP_SYNC_EN
              nxt_d   = step_val;
              state_d = WAIT_EDGE;
`else
              cur_d   = step_val;
              upd_d   = 1'b1;
              state_d = (step_val == tgt_q) ? IDLE : RAMP;
`endif
            end else begin
              pre_d = pre_q + 1'b1;
            end
          end
`ifdef PWM_RAMP_SYNC_EN
          WAIT_EDGE: begin
            if (period_end) begin
              cur_d   = nxt_q;
              upd_d   = 1'b1;
              pre_d   = '0;
              state_d = (nxt_q == tgt_q) ? IDLE : RAMP;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  // State registers; the update pulse is cleared every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cur_q   <= '0;
      tgt_q   <= '0;
      pre_q   <= '0;
      upd_q   <= 1'b0;
`ifdef PWM_RAMP_SYNC_EN
      nxt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      pre_q   <= pre_d;
      upd_q   <= upd_d;
`ifdef PWM_RAMP_SYNC_EN
      nxt_q   <= nxt_d;
`endif
    end
  end

  assign duty_out = cur_q;
  assign duty_upd = upd_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Directed testbench for pwm_duty_ramp (RATE_DIV=4, period_end every 8 clocks).
// Follows the PWM_RAMP_SYNC_EN define of the build for commit timing.
module tb_pwm_duty_ramp;

  localparam int WIDTH    = 8;
  localparam int RATE_DIV = 4;

  logic             clk;
  logic             rst_n;
  logic             ena;
  logic [WIDTH-1:0] tgt_duty;
  logic             tgt_load;
  logic [3:0]       step_size;
  logic             period_end;
  logic [WIDTH-1:0] duty_out;
  logic             duty_upd;
  logic             busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit pe_auto = 0;
  bit pe_sampled = 0;

  pwm_duty_ramp #(.WIDTH(WIDTH), .RATE_DIV(RATE_DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .tgt_duty   (tgt_duty),
    .tgt_load   (tgt_load),
    .step_size  (step_size),
    .period_end (period_end),
    .duty_out   (duty_out),
    .duty_upd   (duty_upd),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample just after the edge, then drive the next inputs
  task automatic tick();
    @(posedge clk);
    #1;
    pe_sampled = period_end;
    cyc++;
    tgt_load   = 1'b0;
    period_end = pe_auto && (cyc % 8 == 0);
  endtask

  function automatic int model_next(input int cur, input int tgt, input int stp);
    int s;
    s = (stp == 0) ? 1 : stp;
    if (tgt > cur) return (cur + s > tgt) ? tgt : cur + s;
    else           return (cur - s < tgt) ? tgt : cur - s;
  endfunction

  task automatic wait_commit(input string tag, input int exp, input bit exp_busy, input int ref_c);
    logic [WIDTH-1:0] prev;
    bit got;
    bit moved;
    prev  = duty_out;
    got   = 0;
    moved = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      tick();
      if (duty_upd === 1'b1) got = 1;
      else if (duty_out !== prev) moved = 1;
    end
    chk({tag, " upd_seen"}, got, 1);
    chk({tag, " no_move_without_upd"}, moved, 0);
    if (got) begin
      chk({tag, " duty"}, duty_out, exp);
      chk({tag, " busy"}, busy, exp_busy);
`ifdef PWM_RAMP_SYNC_EN
      chk({tag, " on_period_end"}, pe_sampled, 1);
`else
      if (ref_c >= 0) chk({tag, " interval"}, cyc - ref_c, RATE_DIV);
`endif
    end
  endtask

  task automatic do_load(input int tgt, input int stp, output int ref_c);
    tgt_duty  = tgt[WIDTH-1:0];
    step_size = stp[3:0];
    tgt_load  = 1'b1;
    tick();
    ref_c = cyc;
  endtask

  task automatic ramp(input string tag, input int tgt, input int stp, input int nmax,
                      inout int cur_e, inout int ref_c);
    for (int k = 0; k < nmax && cur_e != tgt; k++) begin
      cur_e = model_next(cur_e, tgt, stp);
      wait_commit(tag, cur_e, cur_e != tgt, ref_c);
      ref_c = cyc;
    end
  endtask

  initial begin
    int cur_e;
    int ref_c;
    bit any_upd;
    bit moved;

    rst_n      = 1'b0;
    ena        = 1'b1;
    tgt_duty   = '0;
    tgt_load   = 1'b0;
    step_size  = '0;
    period_end = 1'b0;

    #2;
    chk("reset duty_out", duty_out, 0);
    chk("reset busy", busy, 0);
    chk("reset duty_upd", duty_upd, 0);
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    pe_auto = 1;

    // Ramp up 0 -> 10 in steps of 3
    cur_e = 0;
    do_load(10, 3, ref_c);
    chk("up busy after load", busy, 1);
    ramp("up", 10, 3, 10, cur_e, ref_c);
    chk("up final", duty_out, 10);

    // Retarget while a step is pending: 10 -> toward 200, then load 50
    do_load(200, 15, ref_c);
    ramp("retgt_pre", 200, 15, 6, cur_e, ref_c);
    chk("retgt at 100", duty_out, 100);
    pe_auto    = 0;
    period_end = 1'b0;
`ifdef PWM_RAMP_SYNC_EN
    repeat (6) tick();
`else
    repeat (2) tick();
`endif
    tgt_duty   = 8'd50;
    tgt_load   = 1'b1;
    period_end = 1'b1;
    tick();
    ref_c = cyc;
    chk("retgt no upd", duty_upd, 0);
    chk("retgt duty held", duty_out, 100);
    chk("retgt busy", busy, 1);
    pe_auto = 1;
    ramp("retgt_post", 50, 15, 10, cur_e, ref_c);
    chk("retgt final", duty_out, 50);

    // Up to 0xFE, then saturating descent to 0 with step 15
    do_load(254, 15, ref_c);
    ramp("sat_up", 254, 15, 40, cur_e, ref_c);
    chk("sat_up final", duty_out, 254);
    do_load(0, 15, ref_c);
    ramp("sat_dn", 0, 15, 40, cur_e, ref_c);
    chk("sat_dn final", duty_out, 0);
    chk("sat_dn busy", busy, 0);

    // step_size 0 acts as 1; ena=0 freezes everything
    do_load(2, 0, ref_c);
    ramp("step0", 2, 0, 1, cur_e, ref_c);
    ena     = 1'b0;
    any_upd = 0;
    moved   = 0;
    repeat (20) begin
      tick();
      if (duty_upd !== 1'b0) any_upd = 1;
      if (duty_out !== 8'd1) moved = 1;
    end
    chk("freeze no upd", any_upd, 0);
    chk("freeze duty held", moved, 0);
    chk("freeze busy held", busy, 1);
    ena   = 1'b1;
    ref_c = cyc;
    ramp("step0_post", 2, 0, 4, cur_e, ref_c);
    chk("step0 final", duty_out, 2);

    // Asynchronous reset in the middle of a ramp, during an update pulse
    do_load(100, 7, ref_c);
    ramp("pre_rst", 100, 7, 2, cur_e, ref_c);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst duty_out", duty_out, 0);
    chk("async rst busy", busy, 0);
    chk("async rst duty_upd", duty_upd, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cur_e = 0;

    // period_end held low: 0 -> 8 in steps of 4
    pe_auto    = 0;
    period_end = 1'b0;
    do_load(8, 4, ref_c);
`ifdef PWM_RAMP_SYNC_EN
    any_upd = 0;
    repeat (20) begin
      tick();
      if (duty_upd !== 1'b0) any_upd = 1;
    end
    chk("nope no upd", any_upd, 0);
    chk("nope duty held", duty_out, 0);
    chk("nope busy", busy, 1);
    period_end = 1'b1;
    tick();
    chk("nope pulse upd", duty_upd, 1);
    chk("nope pulse duty", duty_out, 4);
    cur_e   = 4;
    pe_auto = 1;
    ramp("nope_post", 8, 4, 4, cur_e, ref_c);
`else
    ramp("nope", 8, 4, 4, cur_e, ref_c);
`endif
    chk("nope final", duty_out, 8);
    chk("nope final busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
